mem_bus_arbiter: RTL

Two-requester arbiter for the single shared memory port (`addr_bus`, data, `wr_en`) that the CPU uses for instruction fetch, operand loads and write-back. Port 0 is the CPU core; port 1 is a secondary master (boot loader / DMA).
- Grants ownership with a registered req/gnt handshake and round-robin fairness.
- Muxes the owner's address, write data and write enable onto the memory side.
- Inserts one idle turnaround cycle between owners so the bus never carries two drivers.

---
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared memory bus, with one idle turnaround cycle between owners.
// Optional feature: define ARB_PREEMPT_EN to force a handover after MAX_HOLD owned cycles when the other port waits.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module mem_bus_arbiter #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int ADDR_SIZE = `ADDR_SIZE,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  input  logic                 wr0,
  input  logic                 wr1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_wr_en,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [1:0]           owner,
  output logic                 preempt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  state_t     state;
  logic       last_owner;
  logic [1:0] pick;
  logic       expire0;
  logic       expire1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must lie in 2..255");
  end

  // Winner of a fresh arbitration: a tie goes to the port that did not own the bus last.
  always_comb begin
    pick = 2'b00;
    if (req0 && req1)
      pick = last_owner ? 2'b01 : 2'b10;
    else if (req0)
      pick = 2'b01;
    else if (req1)
      pick = 2'b10;
  end

`ifdef ARB_PREEMPT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       preempt_r;

  assign expire0 = (hold_cnt == HOLD_LAST) && req1;
  assign expire1 = (hold_cnt == HOLD_LAST) && req0;

  // Counter sits at 0 outside ownership, so it reads 0 during the first owned cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= 8'd0;
      preempt_r <= 1'b0;
    end else begin
      preempt_r <= ((state == OWN0) && req0 && expire0) ||
                   ((state == OWN1) && req1 && expire1);
      if (state == IDLE || state == TURN)
        hold_cnt <= 8'd0;
      else if (hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign preempt = preempt_r;
`else
  assign expire0 = 1'b0;
  assign expire1 = 1'b0;
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      owner      <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE, TURN: begin
          case (pick)
            2'b01: begin
              state <= OWN0;
              gnt0  <= 1'b1;
              gnt1  <= 1'b0;
              owner <= 2'b01;
            end
            2'b10: begin
              state <= OWN1;
              gnt0  <= 1'b0;
              gnt1  <= 1'b1;
              owner <= 2'b10;
            end
            default: begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              owner <= 2'b00;
            end
          endcase
        end
        OWN0: begin
          if (!req0 || expire0) begin
            state      <= TURN;
            gnt0       <= 1'b0;
            owner      <= 2'b00;
            last_owner <= 1'b0;
          end
        end
        OWN1: begin
          if (!req1 || expire1) begin
            state      <= TURN;
            gnt1       <= 1'b0;
            owner      <= 2'b00;
            last_owner <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          owner <= 2'b00;
        end
      endcase
    end
  end

  // Bus side is steered purely by the grant flops, so a non-owner can never reach the memory.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_wr_en = wr0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_wr_en = wr1;
    end
  end

  assign rdata = mem_rdata;

endmodule
